bus_arbiter: RTL

BUS_ARBITER -- requirements
Module: bus_arbiter

---
 rtl/bus_arbiter_pkg.sv | 20 ++
 rtl/bus_arbiter_rr_picker.sv | 34 +++
 rtl/bus_arbiter.sv | 117 +++++++++++
 3 files changed

// File: rtl/bus_arbiter_pkg.sv
// Shared definitions for the bus arbiter: FSM encoding, default sizing and
// the index-width helper used by the top and the round-robin picker.
package bus_arbiter_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_OWN  = 2'b01,
    ST_TURN = 2'b10
  } state_t;

  localparam int unsigned DEF_NREQ     = 3;
  localparam int unsigned DEF_MAX_HOLD = 16;
  localparam int unsigned CE_W         = 8;

  // Width of a master index; never zero so single-master builds stay legal.
  function automatic int unsigned idx_w(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/bus_arbiter_rr_picker.sv
// Combinational round-robin select: the first requester after last_owner_i
// (modulo NREQ) wins.
module rr_picker
  import bus_arbiter_pkg::*;
#(
  parameter int unsigned NREQ = DEF_NREQ,
  parameter int unsigned IW   = idx_w(NREQ)
) (
  input  logic [NREQ-1:0] req_i,
  input  logic [IW-1:0]   last_owner_i,
  output logic            valid_o,
  output logic [IW-1:0]   winner_o
);

  int unsigned w_best;
  int unsigned w_dist;

  // Distance 0 is the master just after last_owner, NREQ-1 is last_owner itself.
  always_comb begin
    valid_o  = 1'b0;
    winner_o = '0;
    w_best   = NREQ;
    w_dist   = 0;
    for (int unsigned j = 0; j < NREQ; j++) begin
      w_dist = (j + NREQ - 1 - 32'(last_owner_i)) % NREQ;
      if (req_i[j] && (w_dist < w_best)) begin
        w_best   = w_dist;
        valid_o  = 1'b1;
        winner_o = IW'(j);
      end
    end
  end

endmodule

// File: rtl/bus_arbiter.sv
// Round-robin bus arbiter with a dead TURN cycle between owners and an
// optional hold limit that forces handover when other masters are waiting.
module bus_arbiter
  import bus_arbiter_pkg::*;
#(
  parameter int unsigned NREQ     = DEF_NREQ,
  parameter int unsigned MAX_HOLD = DEF_MAX_HOLD
) (
  input  logic                   clk_i,
  input  logic                   rst_ni,
  input  logic [NREQ-1:0]        req_i,
  output logic [NREQ-1:0]        gnt_o,
  input  logic [32*NREQ-1:0]     m_addr_i,
  input  logic [32*NREQ-1:0]     m_wdata_i,
  input  logic [NREQ-1:0]        m_we_i,
  input  logic [2*NREQ-1:0]      m_hb_i,
  input  logic [CE_W*NREQ-1:0]   m_ce_i,
  output logic [31:0]            bus_addr_o,
  output logic [31:0]            bus_data_o,
  output logic                   bus_we_o,
  output logic [1:0]             bus_hb_o,
  output logic [CE_W-1:0]        bus_ce_o,
  output logic [idx_w(NREQ)-1:0] owner_o,
  output logic                   busy_o
);

  localparam int unsigned IW = idx_w(NREQ);
  localparam int unsigned CW = (MAX_HOLD > 1) ? $clog2(MAX_HOLD) : 1;
  localparam logic [CW-1:0] HOLD_LAST = CW'((MAX_HOLD == 0) ? 0 : MAX_HOLD - 1);

  state_t            r_state;
  logic [IW-1:0]     r_owner;
  logic [IW-1:0]     r_last;
  logic [CW-1:0]     r_cnt;
  logic [NREQ-1:0]   r_gnt;

  logic              w_valid;
  logic [IW-1:0]     w_winner;
  logic [NREQ-1:0]   w_owner_mask;
  logic              w_owner_req;
  logic              w_others;
  logic              w_hold_hit;

  rr_picker #(
    .NREQ (NREQ),
    .IW   (IW)
  ) u_picker (
    .req_i        (req_i),
    .last_owner_i (r_last),
    .valid_o      (w_valid),
    .winner_o     (w_winner)
  );

  assign w_owner_mask = NREQ'(1) << r_owner;
  assign w_owner_req  = |(req_i & w_owner_mask);
  assign w_others     = |(req_i & ~w_owner_mask);
  assign w_hold_hit   = (MAX_HOLD != 0) && (r_cnt == HOLD_LAST) && w_others;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_state <= ST_IDLE;
      r_owner <= '0;
      r_last  <= IW'(NREQ - 1);
      r_cnt   <= '0;
      r_gnt   <= '0;
    end else begin
      case (r_state)
        ST_IDLE, ST_TURN: begin
          if (w_valid) begin
            r_state <= ST_OWN;
            r_owner <= w_winner;
            r_gnt   <= NREQ'(1) << w_winner;
            r_cnt   <= '0;
          end else begin
            r_state <= ST_IDLE;
          end
        end
        ST_OWN: begin
          if (!w_owner_req || w_hold_hit) begin
            r_state <= ST_TURN;
            r_gnt   <= '0;
            r_last  <= r_owner;
          end else if (r_cnt != HOLD_LAST) begin
            // Saturate so a competitor arriving late is served at once.
            r_cnt <= r_cnt + 1'b1;
          end
        end
        default: begin
          r_state <= ST_IDLE;
          r_gnt   <= '0;
        end
      endcase
    end
  end

  always_comb begin
    bus_addr_o = '0;
    bus_data_o = '0;
    bus_we_o   = 1'b0;
    bus_hb_o   = '0;
    bus_ce_o   = '0;
    for (int unsigned k = 0; k < NREQ; k++) begin
      if ((r_state == ST_OWN) && (r_owner == IW'(k))) begin
        bus_addr_o = m_addr_i[32*k +: 32];
        bus_data_o = m_wdata_i[32*k +: 32];
        bus_we_o   = m_we_i[k];
        bus_hb_o   = m_hb_i[2*k +: 2];
        bus_ce_o   = m_ce_i[CE_W*k +: CE_W];
      end
    end
  end

  assign gnt_o   = r_gnt;
  assign owner_o = r_owner;
  assign busy_o  = |r_gnt;

endmodule
